// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: default operand width,
// controller state encoding and counter sizing.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  localparam int RSA_CNT_W = $clog2(RSA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    UPDATE,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mod_exp_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n,
// scanning b MSB first, one bit per clock.
module modmul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam int XW = WIDTH + 2;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             run_q, run_d;

  logic [CW-1:0]    bit_sel;
  logic [XW-1:0]    nx;
  logic [XW-1:0]    t0;
  logic [XW-1:0]    t1;
  logic [WIDTH-1:0] t2;

  // One interleaved step; the load cycle already
  // consumes the MSB of b starting from acc = 0.
  always_comb begin
    nx      = {2'b00, n};
    bit_sel = load ? CW'(WIDTH - 1) : idx_q;
    t0      = load ? '0 : {1'b0, acc_q, 1'b0};
    t1      = (t0 >= nx) ? (t0 - nx) : t0;
    if (b[bit_sel]) t1 = t1 + {2'b00, a};
    t2      = (t1 >= nx) ? (t1[WIDTH-1:0] - n)
                         : t1[WIDTH-1:0];
    acc_d   = acc_q;
    idx_d   = idx_q;
    run_d   = run_q;
    if (load) begin
      acc_d = t2;
      idx_d = CW'(WIDTH - 2);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = t2;
      idx_d = idx_q - CW'(1);
      if (idx_q == '0) run_d = 1'b0;
    end
  end

  // Last step in flight: acc is final after this edge.
  always_comb begin
    done = run_q && (idx_q == '0) && !load;
    p    = acc_q;
  end

  // Accumulator and bit index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mod_exp.sv
// Constant-time right-to-left square-and-multiply
// modular exponentiator built on two serial multipliers.
module mod_exp
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = cnt_w(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    k_q, k_d;
  logic             first_q, first_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] prod, sq;
  logic             prod_done, sq_done;
  logic             mul_load, mul_done;
  logic             op_bad, last;

  assign mul_load = (state_q == MUL) && first_q;
  assign mul_done = prod_done && sq_done;
  assign op_bad   = (n_q < WIDTH'(2)) || (b_q >= n_q);
  assign last     = (k_q == CW'(WIDTH - 1));

  modmul_serial #(.WIDTH(WIDTH)) u_prod (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .a    (r_q),
    .b    (b_q),
    .n    (n_q),
    .p    (prod),
    .done (prod_done)
  );

  modmul_serial #(.WIDTH(WIDTH)) u_sq (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .a    (b_q),
    .b    (b_q),
    .n    (n_q),
    .p    (sq),
    .done (sq_done)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; every exponent bit costs the same.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       state_d = op_bad ? DONE : MUL;
      MUL:        if (mul_done) state_d = UPDATE;
      UPDATE:     state_d = last ? DONE : MUL;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, square/multiply update.
  always_comb begin
    b_d     = b_q;
    e_d     = e_q;
    n_d     = n_q;
    r_d     = r_q;
    k_d     = k_q;
    res_d   = res_q;
    err_d   = err_q;
    first_d = first_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          b_d   = base;
          e_d   = exponent;
          n_d   = modulus;
          err_d = 1'b0;
        end
      end
      LOAD: begin
        if (op_bad) begin
          err_d = 1'b1;
          res_d = '0;
        end else begin
          r_d     = WIDTH'(1);
          k_d     = '0;
          first_d = 1'b1;
        end
      end
      MUL: first_d = 1'b0;
      UPDATE: begin
        r_d     = e_q[0] ? prod : r_q;
        b_d     = sq;
        e_d     = e_q >> 1;
        k_d     = k_q + CW'(1);
        first_d = 1'b1;
        if (last) res_d = r_d;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      b_q     <= b_d;
      e_q     <= e_d;
      n_q     <= n_d;
      r_q     <= r_d;
      k_q     <= k_d;
      res_q   <= res_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Status outputs decoded from the controller state.
  always_comb begin
    result = res_q;
    valid  = (state_q == DONE);
    busy   = (state_q == LOAD) || (state_q == MUL) ||
             (state_q == UPDATE);
    err    = err_q && (state_q == DONE);
  end

endmodule
